inst_encoder: RTL

Sequential MIPS instruction encoder and instruction-memory writer: accepts abstract instruction requests (kind plus register/immediate fields) over a valid/ready handshake, packs each into the 32-bit MIPS word that the control decoder later decodes, and writes it into instruction RAM at consecutive word addresses. It is the load-side counterpart of the controller and feeds the same R_TYPE/LW/SW/BEQ/ADDI/ANDI/LUI/J subset.

---
 rtl/inst_encoder_if.sv | 33 +++
 rtl/inst_encoder.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/inst_encoder_if.sv
// Request and instruction-memory write bus between a program source and inst_encoder.
// master drives abstract instruction requests; slave encodes them and writes the RAM.
interface inst_encoder_if #(
    parameter int ADDR_W = 8
) ();
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_kind;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [15:0]       in_imm;
    logic [25:0]       in_target;
    logic              in_last;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   count;

    modport master (
        output start, in_valid, in_kind, in_rs, in_rt, in_rd, in_imm, in_target, in_last,
        input  in_ready, imem_we, imem_addr, imem_wdata, busy, done, err, count
    );

    modport slave (
        input  start, in_valid, in_kind, in_rs, in_rt, in_rd, in_imm, in_target, in_last,
        output in_ready, imem_we, imem_addr, imem_wdata, busy, done, err, count
    );
endinterface

// File: rtl/inst_encoder.sv
// Packs abstract MIPS instruction requests into 32-bit words and writes them
// to instruction RAM at consecutive word addresses starting from 0 on each start.
module inst_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    inst_encoder_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_ERR} state_e;

    typedef enum logic [3:0] {
        K_ADD  = 4'd0,  K_SUB  = 4'd1,  K_AND  = 4'd2,  K_OR   = 4'd3,
        K_SLT  = 4'd4,  K_LW   = 4'd5,  K_SW   = 4'd6,  K_BEQ  = 4'd7,
        K_ADDI = 4'd8,  K_ANDI = 4'd9,  K_LUI  = 4'd10, K_J    = 4'd11
    } kind_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam logic [ADDR_W-1:0] PTR_MAX   = '1;
    localparam logic [ADDR_W:0]   COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              in_ready;
    logic              accept;
    logic [31:0]       enc_word;
    logic              enc_legal;

    assign in_ready = (state_q == S_LOAD) && !bus.start;
    assign accept   = bus.in_valid && in_ready;

    // Field packing; fields a format does not use stay zero whatever the inputs carry.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        enc_word  = '0;
        enc_legal = 1'b1;
        case (bus.in_kind)
            K_ADD:  enc_word = {OP_RTYPE, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, FN_ADD};
            K_SUB:  enc_word = {OP_RTYPE, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, FN_SUB};
            K_AND:  enc_word = {OP_RTYPE, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, FN_AND};
            K_OR:   enc_word = {OP_RTYPE, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, FN_OR};
            K_SLT:  enc_word = {OP_RTYPE, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, FN_SLT};
            K_LW:   enc_word = {OP_LW,   bus.in_rs, bus.in_rt, bus.in_imm};
            K_SW:   enc_word = {OP_SW,   bus.in_rs, bus.in_rt, bus.in_imm};
            K_BEQ:  enc_word = {OP_BEQ,  bus.in_rs, bus.in_rt, bus.in_imm};
            K_ADDI: enc_word = {OP_ADDI, bus.in_rs, bus.in_rt, bus.in_imm};
            K_ANDI: enc_word = {OP_ANDI, bus.in_rs, bus.in_rt, bus.in_imm};
            K_LUI:  enc_word = {OP_LUI,  5'd0,      bus.in_rt, bus.in_imm};
            K_J:    enc_word = {OP_J,    bus.in_target};
            default: enc_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = done_q;
        err_d   = err_q;

        // count follows the write strobe, so it lags the handshake by two edges
        if (we_q && count_q != COUNT_MAX) begin
            count_d = count_q + 1'b1;
        end

        if (bus.start) begin
            state_d = S_LOAD;
            ptr_d   = '0;
            count_d = '0;
            done_d  = 1'b0;
            err_d   = 1'b0;
        end else if (accept) begin
            if (!enc_legal) begin
                err_d   = 1'b1;
                state_d = S_ERR;
            end else begin
                we_d    = 1'b1;
                addr_d  = ptr_q;
                wdata_d = enc_word;
                if (ptr_q != PTR_MAX) begin
                    ptr_d = ptr_q + 1'b1;
                end
                if (bus.in_last) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else if (ptr_q == PTR_MAX) begin
                    // RAM full but program not finished: keep what fits, flag overflow
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            count_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.busy       = (state_q == S_LOAD);
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.count      = count_q;
endmodule
